// File: rtl/motor_pwm_decode_if.sv
// Motor drive bus plus decoded telemetry bundle for motor_pwm_decode.
// master: drive side (drives motor_in, observes results); slave: the decoder.
interface motor_pwm_decode_if #(
    parameter int WINDOW_BITS = 8
);
    logic [5:0]             motor_in;
    logic [WINDOW_BITS-1:0] speed_1;
    logic [WINDOW_BITS-1:0] speed_2;
    logic                   forward_1;
    logic                   forward_2;
    logic [WINDOW_BITS:0]   signed_1;
    logic [WINDOW_BITS:0]   signed_2;
    logic                   fault_1;
    logic                   fault_2;
    logic                   valid_out;

    modport master (
        output motor_in,
        input  speed_1, speed_2, forward_1, forward_2,
        input  signed_1, signed_2, fault_1, fault_2, valid_out
    );

    modport slave (
        input  motor_in,
        output speed_1, speed_2, forward_1, forward_2,
        output signed_1, signed_2, fault_1, fault_2, valid_out
    );
endinterface

// File: rtl/motor_pwm_decode.sv
// Motor drive bus decoder: recovers per-motor duty, direction, signed speed
// and fault flags once per 2^WINDOW_BITS-cycle window.
// Optional macro MOTOR_DECODE_SYNC_EN: routes motor_in through a 2-flop
// synchronizer before all logic (needed for pin / foreign-clock sources).
module motor_pwm_decode #(
    parameter int WINDOW_BITS = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    motor_pwm_decode_if.slave  bus
);
    localparam int W = WINDOW_BITS;
    localparam logic [W-1:0] CNT_LAST = {W{1'b1}};
    localparam logic [W:0]   SAT      = {1'b0, {W{1'b1}}};

    logic [5:0] samp;

`ifdef MOTOR_DECODE_SYNC_EN
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;

    // two-stage synchronizer on the raw drive bus
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.motor_in;
            sync2_q <= sync1_q;
        end
    end
    assign samp = sync2_q;
`else
    assign samp = bus.motor_in;
`endif

    // index 0 = motor 1, index 1 = motor 2
    logic [1:0] en_s;
    logic [1:0] ina_s;
    logic [1:0] inb_s;
    assign en_s  = {samp[0], samp[5]};
    assign ina_s = {samp[2], samp[4]};
    assign inb_s = {samp[1], samp[3]};

    logic [W-1:0] win_cnt_q;
    logic         valid_q;
    logic [1:0]   ina_prev_q;
    // prev sample is meaningless on the first edge after reset; without this
    // a steady ina=1 would be reported as a direction change in window one
    logic         prev_vld_q;
    logic [W:0]   acc_q    [2];
    logic [1:0]   flt_q;
    logic [1:0]   chg_q;
    logic [W-1:0] speed_q  [2];
    logic [1:0]   fwd_q;
    logic [W:0]   signed_q [2];
    logic [1:0]   fault_q;

    logic         win_end;
    logic [W:0]   acc_d    [2];
    logic [W-1:0] speed_d  [2];
    logic [W:0]   signed_d [2];
    logic [1:0]   eq_now;
    logic [1:0]   chg_now;
    logic [1:0]   fault_d;

    assign win_end = (win_cnt_q == CNT_LAST);

    // per-motor next-state: closing-window results include the current sample
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            acc_d[m]    = acc_q[m] + {{W{1'b0}}, en_s[m]};
            eq_now[m]   = (ina_s[m] == inb_s[m]);
            chg_now[m]  = prev_vld_q & (ina_s[m] != ina_prev_q[m]);
            speed_d[m]  = (acc_d[m] > SAT) ? SAT[W-1:0] : acc_d[m][W-1:0];
            signed_d[m] = ina_s[m] ? {1'b0, speed_d[m]}
                                   : (~{1'b0, speed_d[m]} + {{W{1'b0}}, 1'b1});
            fault_d[m]  = flt_q[m] | eq_now[m] | chg_q[m] | chg_now[m];
        end
    end

    // window counter, accumulators, trackers and held outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            win_cnt_q  <= '0;
            valid_q    <= 1'b0;
            ina_prev_q <= '0;
            prev_vld_q <= 1'b0;
            flt_q      <= '0;
            chg_q      <= '0;
            fwd_q      <= '0;
            fault_q    <= '0;
            for (int m = 0; m < 2; m++) begin
                acc_q[m]    <= '0;
                speed_q[m]  <= '0;
                signed_q[m] <= '0;
            end
        end else begin
            win_cnt_q  <= win_cnt_q + {{(W-1){1'b0}}, 1'b1};
            valid_q    <= win_end;
            ina_prev_q <= ina_s;
            prev_vld_q <= 1'b1;
            if (win_end) begin
                flt_q   <= '0;
                chg_q   <= '0;
                fwd_q   <= ina_s;
                fault_q <= fault_d;
                for (int m = 0; m < 2; m++) begin
                    acc_q[m]    <= '0;
                    speed_q[m]  <= speed_d[m];
                    signed_q[m] <= signed_d[m];
                end
            end else begin
                flt_q <= flt_q | eq_now;
                chg_q <= chg_q | chg_now;
                for (int m = 0; m < 2; m++) begin
                    acc_q[m] <= acc_d[m];
                end
            end
        end
    end

    assign bus.speed_1   = speed_q[0];
    assign bus.speed_2   = speed_q[1];
    assign bus.forward_1 = fwd_q[0];
    assign bus.forward_2 = fwd_q[1];
    assign bus.signed_1  = signed_q[0];
    assign bus.signed_2  = signed_q[1];
    assign bus.fault_1   = fault_q[0];
    assign bus.fault_2   = fault_q[1];
    assign bus.valid_out = valid_q;
endmodule

// File: doc/motor_pwm_decode.md
Name: motor_pwm_decode

Overview:
- Receive-side counterpart of the motor driver output bundle: samples the 6-bit motor drive bus {en1,ina1,inb1,ina2,inb2,en2} and recovers per-motor duty level, direction and signed speed once per PWM window.
- Used for closed-loop telemetry, for loopback self-test of the drive path, and as the checker in drive-path simulations.
- Sits between the motor pins (or the driver's output) and the control/debug logic.

Parameters:
- WINDOW_BITS, 8, measurement window is 2^WINDOW_BITS cycles. Must equal the driver's PWM counter width.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- motor_in  input  6  drive bus: [5]=en1, [4]=ina1, [3]=inb1, [2]=ina2, [1]=inb2, [0]=en2
- speed_1  output  WINDOW_BITS  measured duty of en1 (high cycles per window), saturated
- speed_2  output  WINDOW_BITS  measured duty of en2, saturated
- forward_1  output  1  motor 1 direction (=ina1 at last sample of window)
- forward_2  output  1  motor 2 direction (=ina2 at last sample of window)
- signed_1  output  WINDOW_BITS+1  two's complement: forward_1 ? +speed_1 : -speed_1
- signed_2  output  WINDOW_BITS+1  same for motor 2
- fault_1  output  1  ina1==inb1 seen on any sample in the window, or ina1 changed within the window
- fault_2  output  1  same for motor 2
- valid_out  output  1  one-cycle strobe: outputs updated this cycle

Behaviour:
- Reset (async assert, sync release): window counter, both accumulators and all fault/change trackers cleared. All outputs are 0, including forward_x and valid_out.
- win_cnt (WINDOW_BITS bits) increments every clock and wraps from 2^W-1 to 0. It is free-running and not aligned to the driver's counter.
  - Exactness holds because the input is periodic with period 2^W: any 2^W consecutive samples contain exactly `level` highs.
- Per cycle, for each motor:
  - acc_x (WINDOW_BITS+1 bits) += en_x.
  - Fault tracker sets if ina_x==inb_x.
  - Change tracker sets if ina_x differs from its previous-cycle sample. The previous-sample register is not cleared at the window boundary.
- Window end is the edge where win_cnt==2^W-1. The sample taken on that edge is included. On that edge:
  - speed_x <= min(acc_x + en_x, 2^W-1). Saturation: a constant-high en gives 2^W highs and reports 2^W-1.
  - forward_x <= ina_x (current sample).
  - signed_x <= forward ? {0,speed} : -{0,speed}. Computed from the new values in the same edge; no extra latency.
  - fault_x <= tracker | (ina_x==inb_x) | change.
  - valid_out <= 1.
  - acc_x <= 0; trackers cleared.
- Latency: outputs reflect the 2^W samples ending at the window-end edge. valid_out is high for exactly one cycle, every 2^W cycles.
- First valid_out: 2^W clock edges after reset release.
- Outputs hold between strobes.
- Reset mid-window: the partial window is discarded, outputs return to 0 immediately, and the counting restarts as after power-up.
- Simultaneous: en sample and window end on the same edge: the sample is counted in the closing window, never the next.
- Motor channels are fully independent; a fault on one does not affect the other.

Optional Feature:
- MOTOR_DECODE_SYNC_EN defined:
  - motor_in passes through a 2-flop synchronizer (reset to 0) before all logic.
  - Adds 2 cycles of input latency. The first window after reset includes 2 zero samples and reports level-2 at most.
  - Later windows are exact.
  - Required when motor_in comes from pins or another clock domain.
- Undefined: motor_in is sampled directly. Only valid for same-clock sources.

Test Plan:
- PWM level 0x80 on both en, ina=1/inb=0 both motors, run 3 windows -> each valid_out: speed=128, forward=1, signed=+128 (9'h080), faults=0.
- Motor 1 level 0x40, ina1=0/inb1=1; motor 2 level 0x00 forward -> signed_1=-64 (9'h1C0), forward_1=0, speed_2=0, signed_2=0.
- en1 held constant 1, en2 level 0xFF -> speed_1=255 (saturated), speed_2=255; valid_out period exactly 256 cycles.
- ina2=inb2=1 for a single cycle mid-window, then normal -> fault_2=1 for that window only, fault_1=0, next window fault_2=0. Flip ina1 mid-window -> fault_1=1 that window.
- Assert rst_in asynchronously at cycle 100 of a window with outputs non-zero -> all outputs 0 at once; next valid_out exactly 256 edges after release, with correct values.
- Phase sweep: driver PWM counter offset 0..255 relative to reset release, level 0x37 -> speed=55 for every offset (repeat with MOTOR_DECODE_SYNC_EN: first window ≤53, thereafter 55).
